// File: rtl/fetch_pkg.sv
// Shared widths, constants and types for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned PC_W       = 12;
  localparam int unsigned INST_W     = 19;
  localparam int unsigned FQ_DEPTH   = 4;
  localparam int unsigned FQ_CNT_W   = 3;
  localparam int unsigned FQ_ENTRY_W = INST_W + PC_W;

  localparam logic [INST_W-1:0] HALT_INST = 19'h7FFFF;
  localparam logic [INST_W-1:0] NOP_INST  = '0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Four-entry instruction queue of {inst, pc+1}; flush empties it in one edge.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [FQ_ENTRY_W-1:0] data_i,
  output logic [FQ_CNT_W-1:0]   count_o,
  output logic [FQ_ENTRY_W-1:0] head_o
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);

  logic [FQ_ENTRY_W-1:0] mem_q [FQ_DEPTH];
  logic [PTR_W-1:0]      rd_q, rd_d;
  logic [PTR_W-1:0]      wr_q, wr_d;
  logic [FQ_CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PTR_W'(1);
      if (pop_i)  rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + FQ_CNT_W'(push_i) - FQ_CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is only observed while the count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: registered single-outstanding memory requests feeding a
// 4-entry queue, with redirect flush, in-flight drop and halt handling.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [PC_W-1:0]   if_pc,
  output logic              halted
);

  fetch_state_e        state_q, state_d;
  logic [PC_W-1:0]     fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]     target_q, target_d;
  logic                req_q, req_d;

  logic                push, pop, flush, ack_hs, fq_valid;
  logic                room_push, room_nopush;
  logic [FQ_CNT_W-1:0] fq_count, cnt_push, cnt_nopush;
  fq_entry_t           fq_head, push_entry;

  assign fq_valid   = (fq_count != '0);
  assign pop        = fq_valid && !stall && !redirect;
  assign ack_hs     = req_q && imem_ack;
  assign push_entry = '{inst: imem_data, pc: fetch_pc_q + PC_W'(1)};

  // Only one request is ever outstanding, so "room" means the queue will still
  // have a free slot after this edge's push/pop.
  assign cnt_push    = fq_count + FQ_CNT_W'(!pop);
  assign cnt_nopush  = fq_count - FQ_CNT_W'(pop);
  assign room_push   = (cnt_push < FQ_CNT_W'(FQ_DEPTH));
  assign room_nopush = (cnt_nopush < FQ_CNT_W'(FQ_DEPTH));

  fetch_fifo u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (push_entry),
    .count_o (fq_count),
    .head_o  (fq_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= '0;
      target_q   <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
      req_q      <= req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    req_d      = req_q;
    push       = 1'b0;
    flush      = redirect;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          // An unacked request cannot be withdrawn: keep its address on the bus.
          if (req_q && !imem_ack) begin
            state_d  = DROP;
            target_d = redirect_pc;
          end else begin
            fetch_pc_d = redirect_pc;
            req_d      = 1'b1;
          end
        end else if (ack_hs) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_W'(1);
          if (imem_data == HALT_INST) begin
            state_d = HALT;
            req_d   = 1'b0;
          end else begin
            req_d = room_push;
          end
        end else if (!req_q) begin
          req_d = room_nopush;
        end
      end
      DROP: begin
        if (redirect) target_d = redirect_pc;
        if (ack_hs) begin
          state_d    = FETCH;
          fetch_pc_d = redirect ? redirect_pc : target_q;
          req_d      = 1'b1;
        end
      end
      HALT: begin
        req_d = 1'b0;
        if (redirect) begin
          state_d    = FETCH;
          fetch_pc_d = redirect_pc;
          req_d      = 1'b1;
        end
      end
      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    imem_req  = req_q;
    imem_addr = fetch_pc_q;
    if_valid  = fq_valid;
    if_inst   = fq_valid ? fq_head.inst : NOP_INST;
    if_pc     = fq_valid ? fq_head.pc : '0;
    halted    = (state_q == HALT);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, corner-case sequences and a
// randomized run checked against an instruction-stream reference model.
module tb_fetch_unit;

  localparam logic [18:0] HALT_W = 19'h7FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [18:0] imem_data = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        if_valid;
  logic [18:0] if_inst;
  logic [11:0] if_pc;
  logic        halted;

  logic [18:0] mem [4096];
  int          ack_delay = 0;   // negative selects a random 0..3 wait per request
  int          wait_left = -1;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .halted      (halted)
  );

  // Memory: an ack seen at the previous negedge completed on the posedge between.
  always @(negedge clk) begin
    if (imem_ack) wait_left = -1;
    if (!imem_req) begin
      imem_ack  = 1'b0;
      wait_left = -1;
    end else begin
      if (wait_left < 0) wait_left = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
      if (wait_left == 0) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
      end else begin
        imem_ack  = 1'b0;
        wait_left--;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack(input logic req, input logic [11:0] addr, input logic v,
                                       input logic [18:0] inst, input logic [11:0] pc,
                                       input logic h);
    return {18'h0, req, (req ? addr : 12'h000), v, inst, pc, h};
  endfunction

  function automatic logic [63:0] obs();
    return pack(imem_req, imem_addr, if_valid, if_inst, if_pc, halted);
  endfunction

  typedef struct {
    logic        stall;
    logic        redir;
    logic [11:0] rpc;
    logic        req;
    logic [11:0] addr;
    logic        valid;
    logic [18:0] inst;
    logic [11:0] pc;
    logic        halted;
  } vec_t;

  vec_t        tbl [16];
  logic [11:0] exp_pc;
  logic [11:0] prev_addr;
  logic [11:0] rpc;
  logic [18:0] exp_word;
  bit          halt_seen, expect_empty, prev_pend;
  int          pops;

  initial begin
    // Expected outputs at each sample, then the inputs driven for the next edge.
    tbl[0]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h000, 1'b0, 19'h00000, 12'h000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h001, 1'b1, 19'h0AAAA, 12'h001, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h002, 1'b1, 19'h0BBBB, 12'h002, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h003, 1'b1, 19'h0CCCC, 12'h003, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 19'h7FFFF, 12'h004, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 19'h00000, 12'h000, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 12'h010, 1'b0, 12'h000, 1'b0, 19'h00000, 12'h000, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h010, 1'b0, 19'h00000, 12'h000, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h011, 1'b1, 19'h30000, 12'h011, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h012, 1'b1, 19'h30000, 12'h011, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h013, 1'b1, 19'h30000, 12'h011, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 19'h30000, 12'h011, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 19'h30000, 12'h011, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h014, 1'b1, 19'h30001, 12'h012, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h015, 1'b1, 19'h30002, 12'h013, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h016, 1'b1, 19'h30003, 12'h014, 1'b0};

    for (int a = 0; a < 4096; a++) mem[a] = '0;
    mem[0] = 19'h0AAAA;  mem[1] = 19'h0BBBB;  mem[2] = 19'h0CCCC;  mem[3] = HALT_W;
    for (int a = 0; a < 8; a++) mem[16 + a] = 19'h30000 + 19'(a);
    mem[12'h005] = 19'h05555;  mem[12'h040] = 19'h04040;
    mem[12'h007] = 19'h07777;  mem[12'h020] = 19'h02020;
    mem[12'hFFF] = 19'h0FFF0;

    // Reset state, then release; the vector table starts at the first sample after release.
    repeat (3) step();
    check("reset_state", obs(), 64'h0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("vec%0d", i), obs(),
            pack(tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].inst, tbl[i].pc, tbl[i].halted));
      stall       = tbl[i].stall;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
    end

    // Redirect while a delayed request is in flight: old address held, data dropped.
    redirect = 1'b1;  redirect_pc = 12'h005;  ack_delay = 3;
    step();
    check("drop_req5", obs(), pack(1'b1, 12'h005, 1'b0, 19'h0, 12'h0, 1'b0));
    redirect_pc = 12'h040;
    for (int c = 0; c < 3; c++) begin
      step();
      redirect = 1'b0;
      check($sformatf("drop_hold%0d", c), obs(), pack(1'b1, 12'h005, 1'b0, 19'h0, 12'h0, 1'b0));
    end
    ack_delay = 0;
    step();
    check("drop_resume", obs(), pack(1'b1, 12'h040, 1'b0, 19'h0, 12'h0, 1'b0));
    step();
    check("drop_first", obs(), pack(1'b1, 12'h041, 1'b1, 19'h04040, 12'h041, 1'b0));

    // Redirect on the same edge as the ack of addr 7.
    redirect = 1'b1;  redirect_pc = 12'h007;
    step();
    check("ackredir_req7", obs(), pack(1'b1, 12'h007, 1'b0, 19'h0, 12'h0, 1'b0));
    redirect_pc = 12'h020;
    step();
    redirect = 1'b0;
    check("ackredir_next", obs(), pack(1'b1, 12'h020, 1'b0, 19'h0, 12'h0, 1'b0));
    step();
    check("ackredir_word", obs(), pack(1'b1, 12'h021, 1'b1, 19'h02020, 12'h021, 1'b0));

    // PC wrap at 12'hFFF, then asynchronous reset while a request waits.
    redirect = 1'b1;  redirect_pc = 12'hFFF;
    step();
    redirect = 1'b0;
    check("wrap_req", obs(), pack(1'b1, 12'hFFF, 1'b0, 19'h0, 12'h0, 1'b0));
    ack_delay = 10;
    step();
    check("wrap_head", obs(), pack(1'b1, 12'h000, 1'b1, 19'h0FFF0, 12'h000, 1'b0));
    step();
    #1;
    rst = 1'b0;
    #1;
    check("async_reset", obs(), 64'h0);
    @(posedge clk);
    step();
    rst = 1'b1;
    ack_delay = 0;
    step();
    check("post_reset_req", obs(), pack(1'b1, 12'h000, 1'b0, 19'h0, 12'h0, 1'b0));

    // Randomized run against an instruction-stream model.
    rst = 1'b0;
    for (int a = 0; a < 4096; a++) begin
      mem[a] = 19'($urandom());
      if (mem[a] == HALT_W) mem[a] = 19'h0;
      if ($urandom_range(0, 31) == 0) mem[a] = HALT_W;
    end
    ack_delay = -1;
    stall = 1'b0;  redirect = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    exp_pc = '0;  halt_seen = 0;  expect_empty = 0;  prev_pend = 0;  pops = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (expect_empty) begin
        check("rnd_flush", {63'h0, if_valid}, 64'h0);
      end else if (halt_seen) begin
        check("rnd_halt_empty", {62'h0, if_valid, halted}, 64'h1);
      end else if (if_valid) begin
        exp_word = mem[exp_pc];
        check("rnd_stream", {33'h0, if_inst, if_pc}, {33'h0, exp_word, exp_pc + 12'h001});
      end
      if (prev_pend)
        check("rnd_req_hold", {51'h0, imem_req, imem_addr}, {51'h0, 1'b1, prev_addr});
      check("rnd_halt_noreq", {63'h0, halted && imem_req}, 64'h0);
      expect_empty = 0;

      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 19) == 0);
      rpc      = 12'($urandom());
      redirect_pc = rpc;
      if (redirect) begin
        exp_pc = rpc;
        halt_seen = 0;
        expect_empty = 1;
      end else if (if_valid && !stall && !halt_seen) begin
        if (mem[exp_pc] == HALT_W) halt_seen = 1;
        exp_pc = exp_pc + 12'h001;
        pops++;
      end
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
    check("rnd_progress", {63'h0, pops >= 300}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
